// File: rtl/reset_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : reset_sequencer_pkg
// Description : Shared types and constants for the staged reset sequencer:
//               FSM state encoding, register map and status bit layout.
// Revision    : 1.0 - initial release
// ============================================================================
package reset_sequencer_pkg;

  // Sequencer state, exposed as a 2-bit field in the status register
  typedef enum logic [1:0] {
    ST_ASSERT = 2'd0,
    ST_WAIT   = 2'd1,
    ST_RUN    = 2'd2
  } state_e;

  // Avalon word addresses
  localparam logic [2:0] ADDR_STATUS  = 3'd0;
  localparam logic [2:0] ADDR_CONTROL = 3'd1;
  localparam logic [2:0] ADDR_DELAY   = 3'd2;

  // Status register layout
  localparam int STAT_DONE      = 0;
  localparam int STAT_STATE_LSB = 1;
  localparam int STAT_STAGE_LSB = 3;
  localparam int STAT_CAUSE_POR = 8;
  localparam int STAT_CAUSE_PLL = 9;
  localparam int STAT_CAUSE_EXT = 10;
  localparam int STAT_CAUSE_SW  = 11;

  // Control register layout
  localparam int CTRL_SW_RESET  = 0;
  localparam int CTRL_CLR_CAUSE = 1;

  // Stage index width (supports up to 8 staged outputs)
  localparam int STAGE_W = 3;

endpackage : reset_sequencer_pkg
`default_nettype wire

// File: rtl/reset_sequencer_sync2.sv
`default_nettype none
// ============================================================================
// Module      : sync2
// Description : Two-flop synchroniser for an asynchronous level input, with
//               a selectable value loaded by the asynchronous reset.
// Revision    : 1.0 - initial release
// ============================================================================
module sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic r_meta_q;
  logic r_sync_q;

  // Two-stage capture of the asynchronous input into the clk domain
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta_q <= RESET_VAL;
      r_sync_q <= RESET_VAL;
    end else begin
      r_meta_q <= d_i;
      r_sync_q <= r_meta_q;
    end
  end

  assign q_o = r_sync_q;

endmodule : sync2
`default_nettype wire

// File: rtl/reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : reset_sequencer
// Description : Staged reset controller. Holds all reset outputs asserted
//               while a PLL, external or software request is active, then
//               releases them one by one with programmable spacing. Avalon-MM
//               slave exposes reset cause, spacing and a software reset.
// Revision    : 1.0 - initial release
// ============================================================================
module reset_sequencer
  import reset_sequencer_pkg::*;
#(
  parameter int NUM_OUT       = 4,
  parameter int DELAY_W       = 8,
  parameter int DEFAULT_DELAY = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               pll_resetrequest,
  input  logic               ext_reset_req,
  input  logic [2:0]         address,
  input  logic               chipselect,
  input  logic               read,
  input  logic               write,
  input  logic [15:0]        writedata,
  output logic [15:0]        readdata,
  output logic [NUM_OUT-1:0] rst_out_n,
  output logic               done
);

  state_e               state_q, state_d;
  logic [STAGE_W-1:0]   stage_q, stage_d;
  logic [DELAY_W-1:0]   cnt_q, cnt_d;
  logic [NUM_OUT-1:0]   rst_out_n_q, rst_out_n_d;
  logic [DELAY_W-1:0]   delay_q;
  logic                 sw_pulse_q;
  logic [1:0]           arm_q;
  logic                 cause_por_q, cause_pll_q, cause_ext_q, cause_sw_q;

  logic                 w_pll_sync;
  logic                 w_ext_sync;
  logic                 w_req;
  logic                 w_wr_ctrl;
  logic                 w_wr_delay;
  logic                 w_clr_cause;
  logic [DELAY_W-1:0]   w_d_m1;
  logic                 w_unused;

  sync2 #(.RESET_VAL(1'b1)) u_sync_pll (
    .clk (clk),
    .rst (reset),
    .d_i (pll_resetrequest),
    .q_o (w_pll_sync)
  );

  sync2 #(.RESET_VAL(1'b1)) u_sync_ext (
    .clk (clk),
    .rst (reset),
    .d_i (ext_reset_req),
    .q_o (w_ext_sync)
  );

  assign w_req       = w_pll_sync | w_ext_sync | sw_pulse_q;
  assign w_wr_ctrl   = chipselect & write & (address == ADDR_CONTROL);
  assign w_wr_delay  = chipselect & write & (address == ADDR_DELAY);
  assign w_clr_cause = w_wr_ctrl & writedata[CTRL_CLR_CAUSE];
  // A programmed delay of 0 behaves as 1; the counter compares against D-1
  assign w_d_m1      = (delay_q == '0) ? '0 : (delay_q - DELAY_W'(1));
  // Reads have no side effects, so the strobe is intentionally ignored
  assign w_unused    = ^{read, writedata};

  // FSM, stage index, spacing counter and staged outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_ASSERT;
      stage_q     <= '0;
      cnt_q       <= '0;
      rst_out_n_q <= '0;
    end else begin
      state_q     <= state_d;
      stage_q     <= stage_d;
      cnt_q       <= cnt_d;
      rst_out_n_q <= rst_out_n_d;
    end
  end

  // Next-state: any request wins; otherwise release one stage every D cycles
  always_comb begin
    state_d     = state_q;
    stage_d     = stage_q;
    cnt_d       = cnt_q;
    rst_out_n_d = rst_out_n_q;
    if (w_req) begin
      state_d     = ST_ASSERT;
      stage_d     = '0;
      cnt_d       = '0;
      rst_out_n_d = '0;
    end else begin
      case (state_q)
        ST_ASSERT: begin
          state_d     = ST_WAIT;
          stage_d     = '0;
          cnt_d       = '0;
          rst_out_n_d = '0;
        end
        ST_WAIT: begin
          if (cnt_q == w_d_m1) begin
            cnt_d = '0;
            for (int i = 0; i < NUM_OUT; i++) begin
              if (stage_q == STAGE_W'(i)) rst_out_n_d[i] = 1'b1;
            end
            if (stage_q == STAGE_W'(NUM_OUT - 1)) begin
              // Stage field reads 0 once the whole sequence has completed
              state_d = ST_RUN;
              stage_d = '0;
            end else begin
              stage_d = stage_q + STAGE_W'(1);
            end
          end else begin
            // Free-running wrap if the delay was shortened below cnt mid-stage
            cnt_d = cnt_q + DELAY_W'(1);
          end
        end
        ST_RUN: begin
          rst_out_n_d = '1;
        end
        default: begin
          state_d     = ST_ASSERT;
          stage_d     = '0;
          cnt_d       = '0;
          rst_out_n_d = '0;
        end
      endcase
    end
  end

  // Avalon registers, software reset pulse and sticky cause bits
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      delay_q     <= DELAY_W'(DEFAULT_DELAY);
      sw_pulse_q  <= 1'b0;
      arm_q       <= 2'b00;
      cause_por_q <= 1'b1;
      cause_pll_q <= 1'b0;
      cause_ext_q <= 1'b0;
      cause_sw_q  <= 1'b0;
    end else begin
      if (w_wr_delay) delay_q <= writedata[DELAY_W-1:0];
      sw_pulse_q  <= w_wr_ctrl & writedata[CTRL_SW_RESET];
      // Synchronisers still carry their reset value for two cycles after
      // reset; that flush is not a real request and must not log a cause
      arm_q       <= {arm_q[0], 1'b1};
      cause_por_q <= cause_por_q & ~w_clr_cause;
      cause_pll_q <= (cause_pll_q & ~w_clr_cause) | (arm_q[1] & w_pll_sync);
      cause_ext_q <= (cause_ext_q & ~w_clr_cause) | (arm_q[1] & w_ext_sync);
      cause_sw_q  <= (cause_sw_q  & ~w_clr_cause) | sw_pulse_q;
    end
  end

  // Zero-wait-state read mux
  always_comb begin
    readdata = '0;
    case (address)
      ADDR_STATUS: begin
        readdata[STAT_DONE]                  = done;
        readdata[STAT_STATE_LSB +: 2]        = state_q;
        readdata[STAT_STAGE_LSB +: STAGE_W]  = stage_q;
        readdata[STAT_CAUSE_POR]             = cause_por_q;
        readdata[STAT_CAUSE_PLL]             = cause_pll_q;
        readdata[STAT_CAUSE_EXT]             = cause_ext_q;
        readdata[STAT_CAUSE_SW]              = cause_sw_q;
      end
      ADDR_DELAY: begin
        readdata[DELAY_W-1:0] = delay_q;
      end
      default: begin
        readdata = '0;
      end
    endcase
  end

  assign rst_out_n = rst_out_n_q;
  assign done      = (state_q == ST_RUN);

endmodule : reset_sequencer
`default_nettype wire

// File: doc/reset_sequencer.md
# reset_sequencer

Staged reset controller sitting directly downstream of the system PLL wrapper. It consumes the PLL's `resetrequest` output, plus an external and a software reset request. It holds a set of reset outputs asserted while any request is active, then releases them one at a time in a fixed order with a programmable spacing. It exposes a small Avalon-MM slave so software can read the reset cause, set the spacing and trigger a software reset.

## Interface
- `NUM_OUT`, 4, number of staged reset outputs (1..8)
- `DELAY_W`, 8, width of the stage-spacing counter and delay register (≤16)
- `DEFAULT_DELAY`, 16, delay register value after reset
- `clk` input 1, system clock (same clock as the PLL wrapper's Avalon port)
- `reset` input 1, one clock; reset is asynchronous and active-high
- `pll_resetrequest` input 1, from PLL wrapper, asynchronous, active-high
- `ext_reset_req` input 1, board-level request, asynchronous, active-high
- `address` input 3, Avalon word address
- `chipselect` input 1, Avalon select
- `read` input 1, Avalon read strobe
- `write` input 1, Avalon write strobe
- `writedata` input 16, Avalon write data
- `readdata` output 16, Avalon read data, zero wait states
- `rst_out_n` output NUM_OUT, staged active-low resets; bit 0 is released first
- `done` output 1, high when all stages are released

## Operation
- Synchronisers:
  - `pll_resetrequest` and `ext_reset_req` each pass through a 2-flop synchroniser; both flops reset to 1.
  - `req` = synced pll OR synced ext OR `sw_pulse`.
- `sw_pulse` is a one-cycle pulse generated by an Avalon write to address 1 with `writedata[0]`=1.
- FSM states, encoded in a 2-bit field:
  - ASSERT=0: all `rst_out_n`=0, `done`=0, `stage`=0, `cnt`=0. If `req`=0, go to WAIT.
  - WAIT=1: `cnt` increments each cycle. When `cnt`==D-1, set `rst_out_n[stage]`=1 and clear `cnt`. If `stage`==NUM_OUT-1, go to RUN; otherwise increment `stage`.
  - RUN=2: `done`=1, all outputs released.
- From any state, `req`=1 moves to ASSERT on the next edge, and all outputs drop at that edge. This is the highest priority, including mid-sequence.
- D = max(delay_reg, 1). D is read every cycle, so a write during WAIT takes effect immediately. If `cnt` is already ≥ the new D-1, `cnt` wraps through its full range; there is no early release.
- Registers (`readdata` is a combinational mux on `address`; unused bits and addresses read 0):
  - addr 0, status (RO): [0] done, [2:1] state, [5:3] stage, [8] cause_por, [9] cause_pll, [10] cause_ext, [11] cause_sw.
  - addr 1, control (W): [0] sw reset (self-clearing, reads 0), [1] clear all cause bits. If a cause event and a clear occur in the same cycle, the event wins.
  - addr 2, delay (RW): [DELAY_W-1:0].
- Cause bits are sticky. Each is set on the cycle its source's synced request is seen high.
- Writes are accepted only when `chipselect`=1 and `write`=1. `read` has no side effects.
- The `reset` port clears the FSM, synchronisers and registers. The sequencer's own outputs do not reset these, so the delay register survives software, PLL and external resets.

## Timing
- Reset values:
  - `rst_out_n`=0, `done`=0, state=ASSERT.
  - delay=DEFAULT_DELAY, cause_por=1, other cause bits 0.
  - `readdata` = mux of the reset values.
- Async `reset` forces `rst_out_n`=0 immediately, without waiting for a clock.
- Latency from an async request edge to `rst_out_n`=0 is 3 edges: 2 synchroniser edges plus 1 FSM edge.
- `sw_pulse` behaviour:
  - Outputs fall at the edge after the write edge.
  - ASSERT lasts exactly 1 cycle, unless another request is active.
- Release schedule: let T be the edge at which the FSM leaves ASSERT.
  - `rst_out_n[i]` rises at edge T+(i+1)·D.
  - `done` rises at T+NUM_OUT·D, on the same edge as the last stage.
- `readdata` is valid in the same cycle `address` is presented.

## Structure
- Shared package holds:
  - the state enumeration (ASSERT/WAIT/RUN);
  - register address constants (STATUS=0, CONTROL=1, DELAY=2);
  - status bit-position constants.
- One sub-module: `sync2`, a 2-flop synchroniser with a reset value parameter. It is instantiated twice.
- The FSM, counter and Avalon registers live in the top level.

## Test plan
- **Power-up:** assert `reset` for 5 cycles, then release; request inputs low, D=16. Require all four outputs low until the FSM exits ASSERT at edge T. Require `rst_out_n` bits rising at T+16, T+32, T+48 and T+64, with `done` at T+64. Status reads 0x0105.
- **PLL request mid-sequence:** assert `pll_resetrequest` just after stage 1 is released. Require all outputs low within 3 edges, `stage` back to 0, and cause_pll=1. The full sequence restarts after the request drops.
- **Software reset:** write 0x0001 to addr 1 while in RUN. Require outputs low at the next edge and ASSERT held for 1 cycle. Stage 0 is released 16 cycles later; cause_sw=1; addr 1 reads 0.
- **Delay edge cases:**
  - Write 0 to addr 2: stages release on consecutive edges (D=1).
  - Write 0xFF: 255-cycle spacing.
  - The delay register keeps its value across a software reset.
- **Cause clearing:** write 0x0002 to addr 1 in the same cycle that `ext_reset_req` is seen synced high. Require cause_ext=1 afterwards, and all other cause bits 0.
